// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_WAIT_STATES     = 1;
  localparam int unsigned DEF_MAX_DATA_STREAK = 4;
  localparam int unsigned DEF_AW              = 16;
  localparam int unsigned DW                  = 16;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned PERF_W              = 16;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // Memory-side control payload held for the duration of an access.
  typedef struct packed {
    logic          we;
    logic          byte_en;
    logic [DW-1:0] wdata;
  } mem_ctl_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Winner select between fetch and data requesters, with the data-streak
// counter that forces a fetch grant after too many consecutive data grants.
module arb_priority_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic grant_en_i,
  output logic gnt_c_o,
  output logic gnt_valid_c_o
);

  logic [CNT_W-1:0] streak_q, streak_d;
  logic             force_if;

  assign force_if      = if_req_i && (streak_q == CNT_W'(MAX_DATA_STREAK));
  assign gnt_c_o       = (d_req_i && !force_if) ? GNT_D : GNT_IF;
  assign gnt_valid_c_o = if_req_i | d_req_i;

  // Streak only grows while a fetch is actually being passed over.
  always_comb begin
    streak_d = streak_q;
    if (grant_en_i && gnt_valid_c_o) begin
      if (gnt_c_o == GNT_IF) begin
        streak_d = '0;
      end else if (if_req_i && (streak_q < CNT_W'(MAX_DATA_STREAK))) begin
        streak_d = streak_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the IF (fetch) and MEM (load/store) stages.
// Optional stall counters are built when MEM_ARB_PERF_COUNTERS_EN is defined.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES     = DEF_WAIT_STATES,
  parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
  parameter int unsigned AW              = DEF_AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte_en,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_byte_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          if_stall,
  output logic          d_stall,
  output logic          busy
`ifdef MEM_ARB_PERF_COUNTERS_EN
  ,
  output logic [PERF_W-1:0] perf_if_stall_cnt,
  output logic [PERF_W-1:0] perf_d_stall_cnt,
  input  logic              perf_clear
`endif
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             gnt_q, gnt_d;
  logic             if_ack_q, if_ack_d;
  logic             d_ack_q, d_ack_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    d_rdata_q, d_rdata_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  mem_ctl_t         ctl_q, ctl_d;
  logic             busy_q, busy_d;
  logic             gnt_c, gnt_valid_c;

  arb_priority_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .clock        (clock),
    .reset        (reset),
    .if_req_i     (if_req),
    .d_req_i      (d_req),
    .grant_en_i   (state_q == IDLE),
    .gnt_c_o      (gnt_c),
    .gnt_valid_c_o(gnt_valid_c)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    gnt_d      = gnt_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_addr_d = mem_addr_q;
    ctl_d      = ctl_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          gnt_d   = gnt_c;
          wait_d  = CNT_W'(WAIT_STATES);
          state_d = ACCESS;
          if (gnt_c == GNT_D) begin
            mem_addr_d    = d_addr;
            ctl_d.we      = d_we;
            ctl_d.byte_en = d_byte_en;
            ctl_d.wdata   = d_wdata;
          end else begin
            mem_addr_d    = if_addr;
            ctl_d.we      = 1'b0;
            ctl_d.byte_en = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (wait_q == '0) begin
          ctl_d.we = 1'b0;
          state_d  = COMPLETE;
          if (gnt_q == GNT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!ctl_q.we) begin
              d_rdata_d = ctl_q.byte_en ? {8'h00, mem_rdata[7:0]} : mem_rdata;
            end
          end
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      gnt_q      <= GNT_IF;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      mem_addr_q <= '0;
      ctl_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      gnt_q      <= gnt_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      mem_addr_q <= mem_addr_d;
      ctl_q      <= ctl_d;
      busy_q     <= busy_d;
    end
  end

  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = ctl_q.we;
  assign mem_byte_en = ctl_q.byte_en;
  assign mem_wdata   = ctl_q.wdata;
  assign busy        = busy_q;
  assign if_stall    = if_req & ~if_ack_q;
  assign d_stall     = d_req & ~d_ack_q;

`ifdef MEM_ARB_PERF_COUNTERS_EN
  logic [PERF_W-1:0] perf_if_q, perf_if_d;
  logic [PERF_W-1:0] perf_d_q, perf_d_d;

  // Saturating stall-cycle counters; clear wins over counting.
  always_comb begin
    perf_if_d = perf_if_q;
    perf_d_d  = perf_d_q;
    if (perf_clear) begin
      perf_if_d = '0;
      perf_d_d  = '0;
    end else begin
      if (if_stall && (perf_if_q != '1)) perf_if_d = perf_if_q + PERF_W'(1);
      if (d_stall && (perf_d_q != '1))   perf_d_d  = perf_d_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_d_q  <= perf_d_d;
    end
  end

  assign perf_if_stall_cnt = perf_if_q;
  assign perf_d_stall_cnt  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (WAIT_STATES=1, MAX_DATA_STREAK=4).
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_byte_en;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_byte_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        if_stall;
  logic        d_stall;
  logic        busy;
`ifdef MEM_ARB_PERF_COUNTERS_EN
  logic [15:0] perf_if_stall_cnt;
  logic [15:0] perf_d_stall_cnt;
  logic        perf_clear;
`endif

  int vectors = 0;
  int fails   = 0;

  logic [15:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[8:1]];

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .WAIT_STATES(1),
    .MAX_DATA_STREAK(4),
    .AW(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_byte_en  (d_byte_en),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_byte_en(mem_byte_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .if_stall   (if_stall),
    .d_stall    (d_stall),
    .busy       (busy)
`ifdef MEM_ARB_PERF_COUNTERS_EN
    ,
    .perf_if_stall_cnt(perf_if_stall_cnt),
    .perf_d_stall_cnt (perf_d_stall_cnt),
    .perf_clear       (perf_clear)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    if_req    = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_byte_en = 1'b0;
    if_addr   = 16'h0000;
    d_addr    = 16'h0000;
    d_wdata   = 16'h0000;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({if_ack, d_ack, mem_we, mem_byte_en, busy, if_stall, d_stall} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {if_ack, d_ack, mem_we, mem_byte_en, busy, if_stall, d_stall});
    end
    vectors++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      fails++;
      $display("FAIL reset_data got=%h exp=0", {if_rdata, d_rdata, mem_addr, mem_wdata});
    end
  endtask

  task automatic test_fetch();
    do_reset();
    if_addr = 16'h0004;
    if_req  = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (if_ack !== 1'b0 || if_stall !== 1'b1) begin
        fails++;
        $display("FAIL fetch_wait c=%0d ack=%b stall=%b exp ack=0 stall=1", c, if_ack, if_stall);
      end
      tick();
    end
    vectors++;
    if (if_ack !== 1'b1 || if_stall !== 1'b0 || if_rdata !== 16'h1234) begin
      fails++;
      $display("FAIL fetch_ack ack=%b stall=%b rdata=%h exp 1/0/1234", if_ack, if_stall, if_rdata);
    end
    if_req = 1'b0;
    tick();
    vectors++;
    if (if_ack !== 1'b0 || if_rdata !== 16'h1234 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fetch_after ack=%b rdata=%h busy=%b exp 0/1234/0", if_ack, if_rdata, busy);
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    do_reset();
    if_addr   = 16'h0006;
    d_addr    = 16'h0100;
    d_we      = 1'b0;
    d_byte_en = 1'b0;
    if_req    = 1'b1;
    d_req     = 1'b1;
    tick();
    vectors++;
    if (mem_addr !== 16'h0100 || busy !== 1'b1) begin
      fails++;
      $display("FAIL sim_grant mem_addr=%h busy=%b exp 0100/1", mem_addr, busy);
    end
    tick();
    tick();
    vectors++;
    if (d_ack !== 1'b1 || d_rdata !== 16'hBEEF || if_ack !== 1'b0 || if_stall !== 1'b1) begin
      fails++;
      $display("FAIL sim_dack d_ack=%b d_rdata=%h if_ack=%b if_stall=%b exp 1/beef/0/1",
               d_ack, d_rdata, if_ack, if_stall);
    end
    d_req = 1'b0;
    lat = 0;
    while (if_ack !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat != 4 || if_rdata !== 16'h5678) begin
      fails++;
      $display("FAIL sim_fetch latency=%0d rdata=%h exp 4/5678", lat, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    int  we_cycles;
    int  bad;
    bit  got;
    d_addr    = 16'h0010;
    d_we      = 1'b1;
    d_byte_en = 1'b1;
    d_wdata   = 16'h00A5;
    d_req     = 1'b1;
    #1;
    we_cycles = 0;
    bad       = 0;
    got       = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      if (mem_we === 1'b1) begin
        we_cycles++;
        if (mem_addr !== 16'h0010 || mem_wdata !== 16'h00A5 || mem_byte_en !== 1'b1) bad++;
      end
      if (d_ack === 1'b1) got = 1'b1;
      else tick();
    end
    vectors++;
    if (!got || we_cycles != 2 || bad != 0) begin
      fails++;
      $display("FAIL store_strobe ack_seen=%0d we_cycles=%0d bad=%0d exp 1/2/0", got, we_cycles, bad);
    end
    vectors++;
    if (mem_we !== 1'b0 || d_rdata !== 16'hBEEF) begin
      fails++;
      $display("FAIL store_ack mem_we=%b d_rdata=%h exp 0/beef", mem_we, d_rdata);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    vectors++;
    if (d_ack !== 1'b0) begin
      fails++;
      $display("FAIL store_pulse d_ack=%b exp 0", d_ack);
    end
  endtask

  task automatic test_byte_load();
    int lat;
    d_addr    = 16'h0020;
    d_we      = 1'b0;
    d_byte_en = 1'b1;
    d_req     = 1'b1;
    #1;
    lat = 0;
    while (d_ack !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat != 3 || d_rdata !== 16'h00AB) begin
      fails++;
      $display("FAIL byte_load latency=%0d d_rdata=%h exp 3/00ab", lat, d_rdata);
    end
    d_byte_en = 1'b0;
    tick();
    lat = 0;
    while (d_ack !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat != 3 || d_rdata !== 16'h12AB) begin
      fails++;
      $display("FAIL half_load latency=%0d d_rdata=%h exp 3/12ab", lat, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int acks;
    d_addr    = 16'h0030;
    d_we      = 1'b1;
    d_byte_en = 1'b1;
    d_wdata   = 16'h5A5A;
    d_req     = 1'b1;
    tick();
    vectors++;
    if (mem_we !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre mem_we=%b busy=%b exp 1/1", mem_we, busy);
    end
    reset = 1'b0;
    d_req = 1'b0;
    tick();
    vectors++;
    if ({mem_we, mem_byte_en, busy, d_ack, if_ack, d_stall} !== 6'b0 ||
        {mem_addr, mem_wdata, d_rdata, if_rdata} !== 64'h0) begin
      fails++;
      $display("FAIL midrst_clear ctrl=%b data=%h exp 0/0",
               {mem_we, mem_byte_en, busy, d_ack, if_ack, d_stall},
               {mem_addr, mem_wdata, d_rdata, if_rdata});
    end
    reset = 1'b1;
    acks  = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (d_ack !== 1'b0 || busy !== 1'b0) acks++;
    end
    vectors++;
    if (acks != 0) begin
      fails++;
      $display("FAIL midrst_noack activity_cycles=%0d exp 0", acks);
    end
  endtask

  task automatic test_starvation();
    logic exp_pat [10];
    int   n;
    do_reset();
    exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if_addr = 16'h0004;
    d_addr  = 16'h0100;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    n       = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      tick();
      if (if_ack === 1'b1 || d_ack === 1'b1) begin
        vectors++;
        if ((if_ack & d_ack) === 1'b1 || d_ack !== exp_pat[n]) begin
          fails++;
          $display("FAIL starve_grant n=%0d d_ack=%b if_ack=%b exp d_ack=%b", n, d_ack, if_ack, exp_pat[n]);
        end
        n++;
      end
    end
    vectors++;
    if (n != 10) begin
      fails++;
      $display("FAIL starve_count acks=%0d exp 10", n);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    tick();
  endtask

`ifdef MEM_ARB_PERF_COUNTERS_EN
  task automatic test_perf();
    do_reset();
    if_addr = 16'h0004;
    d_addr  = 16'h0100;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    vectors++;
    if (perf_if_stall_cnt !== 16'd10 || perf_d_stall_cnt !== 16'd8) begin
      fails++;
      $display("FAIL perf_count if=%0d d=%0d exp 10/8", perf_if_stall_cnt, perf_d_stall_cnt);
    end
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    vectors++;
    if (perf_if_stall_cnt !== 16'd0 || perf_d_stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL perf_clear if=%0d d=%0d exp 0/0", perf_if_stall_cnt, perf_d_stall_cnt);
    end
    do_reset();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h02] = 16'h1234;
    mem[8'h03] = 16'h5678;
    mem[8'h80] = 16'hBEEF;
    mem[8'h10] = 16'h12AB;
`ifdef MEM_ARB_PERF_COUNTERS_EN
    perf_clear = 1'b0;
`endif
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_byte_load();
    test_reset_mid_access();
    test_starvation();
`ifdef MEM_ARB_PERF_COUNTERS_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
